// File: rtl/ir_operand_path.sv
// Instruction register with decode slices, plus the two operand muxes that
// feed the ALU B input and the register-file write-back port.
// The IR is the only state in this block. The decode fields are cut from the
// registered word, and both muxes are purely combinational.
module ir_operand_path #(
  parameter int unsigned           XLEN     = 64,
  parameter int unsigned           ILEN     = 32,
  parameter logic [ILEN-1:0]       IR_RESET = 32'h0000_0013
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            r_enable,
  input  logic [ILEN-1:0] data_in,
  output logic [ILEN-1:0] data_out,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] doutB,
  input  logic            sinal_mux1,
  output logic [XLEN-1:0] S1,
  input  logic [XLEN-1:0] dout,
  input  logic [XLEN-1:0] soma,
  input  logic            sinal_mux2,
  output logic [XLEN-1:0] S2
);

  logic [ILEN-1:0] ir_q;
  logic [ILEN-1:0] ir_d;

  // Next IR value: load the fetched word when enabled, otherwise hold.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    ir_d = ir_q;
    if (r_enable) begin
      ir_d = data_in;
    end
  end

  // IR register: async reset to the NOP encoding, which takes priority over a load.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      ir_q <= IR_RESET;
    end else begin
      ir_q <= ir_d;
    end
  end

  // Decode fields are slices of the registered word, never of data_in.
  assign data_out = ir_q;
  assign opcode   = ir_q[6:0];
  assign rd       = ir_q[11:7];
  assign funct3   = ir_q[14:12];
  assign rs1      = ir_q[19:15];
  assign rs2      = ir_q[24:20];
  assign funct7   = ir_q[31:25];

  // ALU operand B: register read port or immediate. An unknown select gives all-X.
  always_comb begin
    S1 = '0;
    case (sinal_mux1)
      1'b0:    S1 = doutB;
      1'b1:    S1 = imm;
      default: S1 = 'x;
    endcase
  end

  // Write-back data: ALU result or memory read data. An unknown select gives all-X.
  always_comb begin
    S2 = '0;
    case (sinal_mux2)
      1'b0:    S2 = soma;
      1'b1:    S2 = dout;
      default: S2 = 'x;
    endcase
  end

endmodule

// File: tb/tb_ir_operand_path.sv
// Directed bench for ir_operand_path: IR reset/load/hold, decode slices,
// asynchronous mid-cycle reset, and both operand muxes.
module tb_ir_operand_path;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  logic            clock;
  logic            reset_n;
  logic            r_enable;
  logic [ILEN-1:0] data_in;
  logic [ILEN-1:0] data_out;
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] doutB;
  logic            sinal_mux1;
  logic [XLEN-1:0] S1;
  logic [XLEN-1:0] dout;
  logic [XLEN-1:0] soma;
  logic            sinal_mux2;
  logic [XLEN-1:0] S2;

  int checks = 0;
  int errors = 0;

  ir_operand_path #(.XLEN(XLEN), .ILEN(ILEN), .IR_RESET(32'h0000_0013)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .r_enable   (r_enable),
    .data_in    (data_in),
    .data_out   (data_out),
    .opcode     (opcode),
    .rd         (rd),
    .funct3     (funct3),
    .rs1        (rs1),
    .rs2        (rs2),
    .funct7     (funct7),
    .imm        (imm),
    .doutB      (doutB),
    .sinal_mux1 (sinal_mux1),
    .S1         (S1),
    .dout       (dout),
    .soma       (soma),
    .sinal_mux2 (sinal_mux2),
    .S2         (S2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // Advance one rising edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Check all six decode fields at once.
  task automatic check_decode(input string tag, input logic [6:0] op, input logic [4:0] e_rd,
                              input logic [2:0] f3, input logic [4:0] e_rs1,
                              input logic [4:0] e_rs2, input logic [6:0] f7);
    check({tag, ".opcode"}, 64'(opcode), 64'(op));
    check({tag, ".rd"},     64'(rd),     64'(e_rd));
    check({tag, ".funct3"}, 64'(funct3), 64'(f3));
    check({tag, ".rs1"},    64'(rs1),    64'(e_rs1));
    check({tag, ".rs2"},    64'(rs2),    64'(e_rs2));
    check({tag, ".funct7"}, 64'(funct7), 64'(f7));
  endtask

  // Watchdog: the sequence is short, so this only fires if the run stalls.
  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n    = 1'b0;
    r_enable   = 1'b1;
    data_in    = 32'hFFFF_FFFF;
    imm        = '0;
    doutB      = '0;
    sinal_mux1 = 1'b0;
    dout       = '0;
    soma       = '0;
    sinal_mux2 = 1'b0;

    // Reset overrides a load that is enabled on every edge.
    tick();
    tick();
    check("reset_over_enable", 64'(data_out), 64'h13);
    check_decode("reset_decode", 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0);

    // Release reset away from the edge. The first edge with r_enable=1 loads BEQ x10,x11.
    @(negedge clock);
    reset_n = 1'b1;
    data_in = 32'h00B5_0463;
    #1;
    check("pre_edge_no_load", 64'(data_out), 64'h13);
    check("decode_not_from_data_in", 64'(opcode), 64'h13);
    tick();
    check("first_load", 64'(data_out), 64'h00B5_0463);
    check_decode("beq", 7'h63, 5'd8, 3'd0, 5'd10, 5'd11, 7'd0);

    // Hold for three edges with r_enable=0 while data_in changes.
    r_enable = 1'b0;
    data_in  = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold_%0d", i), 64'(data_out), 64'h00B5_0463);
    end
    check("hold_opcode", 64'(opcode), 64'h63);

    // Mid-cycle async reset: data_out returns to the NOP with no clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", 64'(data_out), 64'h13);
    check("async_reset_opcode", 64'(opcode), 64'h13);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    check("stay_nop_until_load", 64'(data_out), 64'h13);

    // Load SUB x10,x10,x11 to exercise a non-zero funct7 and funct3=0.
    r_enable = 1'b1;
    data_in  = 32'h40B5_0533;
    tick();
    check("second_load", 64'(data_out), 64'h40B5_0533);
    check_decode("sub", 7'h33, 5'd10, 3'd0, 5'd11 - 5'd1, 5'd11, 7'h20);

    // Load a word with every field all-ones except a different funct3 pattern.
    data_in = 32'hFFFF_AFFF;
    tick();
    check_decode("ones", 7'h7F, 5'h1F, 3'd2, 5'h1F, 5'h1F, 7'h7F);
    r_enable = 1'b0;

    // Mux1: both selects switched within one cycle, full 64-bit pass-through.
    doutB      = 64'h0000_0000_0000_0005;
    imm        = 64'hFFFF_FFFF_FFFF_FFFC;
    sinal_mux1 = 1'b0;
    #1;
    check("mux1_doutB", S1, 64'h5);
    sinal_mux1 = 1'b1;
    #1;
    check("mux1_imm", S1, 64'hFFFF_FFFF_FFFF_FFFC);
    imm = 64'h8000_0000_0000_0001;
    #1;
    check("mux1_imm_follow", S1, 64'h8000_0000_0000_0001);

    // Mux2: ALU result then memory data.
    soma       = 64'h0000_0000_0000_0100;
    dout       = 64'hDEAD_BEEF_CAFE_F00D;
    sinal_mux2 = 1'b0;
    #1;
    check("mux2_soma", S2, 64'h100);
    sinal_mux2 = 1'b1;
    #1;
    check("mux2_dout", S2, 64'hDEAD_BEEF_CAFE_F00D);

    // A reset pulse must not disturb either mux output.
    reset_n = 1'b0;
    #1;
    check("mux1_during_reset", S1, 64'h8000_0000_0000_0001);
    check("mux2_during_reset", S2, 64'hDEAD_BEEF_CAFE_F00D);
    tick();
    reset_n = 1'b1;
    #1;
    check("mux1_after_reset", S1, 64'h8000_0000_0000_0001);
    check("mux2_after_reset", S2, 64'hDEAD_BEEF_CAFE_F00D);
    check("ir_after_pulse", 64'(data_out), 64'h13);

    // Switch both selects back and confirm the other inputs reappear.
    sinal_mux1 = 1'b0;
    sinal_mux2 = 1'b0;
    #1;
    check("mux1_back", S1, 64'h5);
    check("mux2_back", S2, 64'h100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ir_operand_path.md
IR_OPERAND_PATH -- requirements
Module: ir_operand_path

Interface
REQ-001 The block SHALL use one clock and one reset: the reset is asynchronous and active-low.
REQ-002 Parameter XLEN, default 64, SHALL set the datapath width of both operand muxes.
REQ-003 Parameter ILEN, default 32, SHALL set the instruction register width.
REQ-004 Parameter IR_RESET, default 32'h00000013 (ADDI x0,x0,0 NOP), SHALL set the instruction register reset value.
REQ-005 The ports SHALL be, one per line (name, direction, width, meaning):
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- r_enable  in  1  IR load enable
- data_in  in  ILEN  instruction word from instruction memory
- data_out  out  ILEN  registered instruction
- opcode  out  7  data_out[6:0]
- rd  out  5  data_out[11:7]
- funct3  out  3  data_out[14:12]
- rs1  out  5  data_out[19:15]
- rs2  out  5  data_out[24:20]
- funct7  out  7  data_out[31:25]
- imm  in  XLEN  sign-extended immediate
- doutB  in  XLEN  register-file read port B
- sinal_mux1  in  1  ALU operand-B select
- S1  out  XLEN  ALU operand B
- dout  in  XLEN  data-memory read data
- soma  in  XLEN  ALU result
- sinal_mux2  in  1  write-back select
- S2  out  XLEN  register-file write data

Function
REQ-006 The IR SHALL capture data_in into data_out on the rising clock edge when r_enable=1.
REQ-007 The IR SHALL hold its value on any clock edge with r_enable=0.
REQ-008 The IR SHALL have a load latency of exactly one clock: a word presented before edge N SHALL be visible on data_out after edge N.
REQ-009 The decode outputs (opcode, rd, funct3, rs1, rs2, funct7) SHALL be pure combinational slices of data_out, never of data_in, and SHALL change only when data_out changes.
REQ-010 Mux1 SHALL be combinational: S1 = doutB when sinal_mux1=0, and S1 = imm when sinal_mux1=1.
REQ-011 Mux2 SHALL be combinational: S2 = soma when sinal_mux2=0, and S2 = dout when sinal_mux2=1.
REQ-012 Mux outputs SHALL pass all XLEN bits unmodified, with no sign or zero extension, truncation or arithmetic.
REQ-013 Mux outputs SHALL NOT depend on clock or reset_n; an input change SHALL propagate with zero clock latency.
REQ-014 A select input at X/Z SHALL produce all-X on that mux output in simulation.
REQ-015 The block SHALL contain no internal state other than the IR.

Reset
REQ-016 When reset_n=0, data_out SHALL become IR_RESET immediately, independent of clock.
REQ-017 With data_out at its reset value, the decode outputs SHALL be: opcode=7'h13, rd=0, funct3=0, rs1=0, rs2=0, funct7=0.
REQ-018 Reset SHALL override r_enable: an edge with reset_n=0 and r_enable=1 SHALL leave data_out at IR_RESET.
REQ-019 Reset deassertion SHALL be sampled so that the first load occurs on the first rising edge with reset_n=1 and r_enable=1.
REQ-020 Reset SHALL NOT affect S1 or S2.
REQ-021 If reset_n is asserted in the middle of a cycle after a load, data_out SHALL return to IR_RESET at once and stay there until a new load.

Verification
REQ-022 Assert reset_n=0 asynchronously mid-cycle after loading 0x00B50463 -> data_out=0x00000013 with no clock edge, and opcode=0x13.
REQ-023 With reset_n=1 and r_enable=1, drive data_in=0x00B50463 (BEQ x10,x11) and clock once -> data_out=0x00B50463, opcode=0x63, rs1=10, rs2=11, funct3=0, rd=8, funct7=0.
REQ-024 Set r_enable=0, change data_in to 0xFFFFFFFF and clock 3 times -> data_out stays 0x00B50463.
REQ-025 Drive doutB=0x0000000000000005 and imm=0xFFFFFFFFFFFFFFFC; set sinal_mux1=0 -> S1=0x5; then set sinal_mux1=1 -> S1=0xFFFFFFFFFFFFFFFC in the same cycle.
REQ-026 Drive soma=0x100 and dout=0xDEADBEEFCAFEF00D; set sinal_mux2=0 -> S2=0x100; then set sinal_mux2=1 -> S2=0xDEADBEEFCAFEF00D, with S1 and S2 unchanged across a reset pulse.
